qkv_row_loader: RTL

QKV_ROW_LOADER -- requirements
Module: qkv_row_loader

---
 rtl/qkv_row_loader_if.sv | 39 +++
 rtl/qkv_row_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/qkv_row_loader_if.sv
// -----------------------------------------------------------------------------
// qkv_row_loader_if
// Bundles the row-stream handshake, the attention start/done handshake and the
// three held Q/K/V matrices exchanged between qkv_row_loader and its
// environment.
//   I_ROW_VLD    upstream row beat valid
//   I_ROW_DATA   one matrix row, element j at bits [j*D_W +: D_W]
//   O_ROW_RDY    loader accepts a row this cycle
//   I_ATTN_DONE  completion from the attention stage
//   O_ATTN_START one-cycle start pulse to the attention stage
//   O_MAT_Q/K/V  held matrices, [row][col] of D_W-bit elements
//   O_BUSY       high from START until I_ATTN_DONE
// Modports: slave = the loader, master = the environment driving rows/done.
// -----------------------------------------------------------------------------
interface qkv_row_loader_if #(
  parameter int D_W = 16,
  parameter int DIM = 16,
  parameter int D_K = 16
);
  logic                             I_ROW_VLD;
  logic [D_K*D_W-1:0]               I_ROW_DATA;
  logic                             O_ROW_RDY;
  logic                             I_ATTN_DONE;
  logic                             O_ATTN_START;
  logic [DIM-1:0][D_K-1:0][D_W-1:0] O_MAT_Q;
  logic [DIM-1:0][D_K-1:0][D_W-1:0] O_MAT_K;
  logic [DIM-1:0][D_K-1:0][D_W-1:0] O_MAT_V;
  logic                             O_BUSY;

  modport slave (
    input  I_ROW_VLD, I_ROW_DATA, I_ATTN_DONE,
    output O_ROW_RDY, O_ATTN_START, O_MAT_Q, O_MAT_K, O_MAT_V, O_BUSY
  );

  modport master (
    output I_ROW_VLD, I_ROW_DATA, I_ATTN_DONE,
    input  O_ROW_RDY, O_ATTN_START, O_MAT_Q, O_MAT_K, O_MAT_V, O_BUSY
  );
endinterface

// File: rtl/qkv_row_loader.sv
// -----------------------------------------------------------------------------
// qkv_row_loader
// Collects DIM rows each of Q, K and V from a valid/ready row stream, holds
// the three matrices for the attention stage, fires a one-cycle start pulse
// and waits for the attention stage to report completion before reloading.
// Ports:
//   I_CLK       the only clock, rising edge
//   I_SYNC_RST  synchronous active-high reset
//   bus         qkv_row_loader_if.slave (row stream, start/done, matrices)
// -----------------------------------------------------------------------------
module qkv_row_loader #(
  parameter int D_W = 16,
  parameter int DIM = 16,
  parameter int D_K = 16
) (
  input  logic             I_CLK,
  input  logic             I_SYNC_RST,
  qkv_row_loader_if.slave  bus
);

  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [2:0] LOAD_Q = 3'd0;
  localparam logic [2:0] LOAD_K = 3'd1;
  localparam logic [2:0] LOAD_V = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;

  typedef logic [DIM-1:0][D_K-1:0][D_W-1:0] mat_t;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mat_t             q_mat_q, q_mat_d;
  mat_t             k_mat_q, k_mat_d;
  mat_t             v_mat_q, v_mat_d;
  logic             row_rdy_q, row_rdy_d;
  logic             attn_start_q, attn_start_d;
  logic             busy_q, busy_d;
  logic             beat_s;
  logic             last_row_s;

  // Next-state, row counter and matrix write decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_mat_d    = q_mat_q;
    k_mat_d    = k_mat_q;
    v_mat_d    = v_mat_q;
    // Ready is a pure function of the registered state, so a beat needs no
    // combinational path from I_ROW_VLD back to O_ROW_RDY.
    beat_s     = bus.I_ROW_VLD && row_rdy_q;
    last_row_s = (cnt_q == CNT_W'(DIM - 1));

    case (state_q)
      LOAD_Q, LOAD_K, LOAD_V: begin
        if (beat_s) begin
          case (state_q)
            LOAD_Q:  q_mat_d[cnt_q] = bus.I_ROW_DATA;
            LOAD_K:  k_mat_d[cnt_q] = bus.I_ROW_DATA;
            default: v_mat_d[cnt_q] = bus.I_ROW_DATA;
          endcase
          if (last_row_s) begin
            cnt_d   = '0;
            state_d = state_q + 3'd1;   // LOAD_Q->LOAD_K->LOAD_V->START
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.I_ATTN_DONE) begin
          state_d = LOAD_Q;
          cnt_d   = '0;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = LOAD_Q;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    row_rdy_d    = (state_d == LOAD_Q) || (state_d == LOAD_K) || (state_d == LOAD_V);
    attn_start_d = (state_d == START);
    busy_d       = (state_d == START) || (state_d == WAIT);
  end

  // State, counter, matrices and output flops with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q      <= LOAD_Q;
      cnt_q        <= '0;
      q_mat_q      <= '0;
      k_mat_q      <= '0;
      v_mat_q      <= '0;
      row_rdy_q    <= 1'b1;
      attn_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      q_mat_q      <= q_mat_d;
      k_mat_q      <= k_mat_d;
      v_mat_q      <= v_mat_d;
      row_rdy_q    <= row_rdy_d;
      attn_start_q <= attn_start_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.O_ROW_RDY    = row_rdy_q;
  assign bus.O_ATTN_START = attn_start_q;
  assign bus.O_BUSY       = busy_q;
  assign bus.O_MAT_Q      = q_mat_q;
  assign bus.O_MAT_K      = k_mat_q;
  assign bus.O_MAT_V      = v_mat_q;

endmodule
